// File: rtl/imm_gen_pkg.sv
// Shared constants and format-select encoding for the RV32I immediate generator.
// IMMGEN_ZICSR_EN (when defined) enables select 5 as the CSR zero-extended immediate.
package imm_gen_pkg;

    localparam int XLEN    = 32;
    localparam int SEL_W   = 3;

    typedef enum logic [SEL_W-1:0] {
        IMM_U   = 3'd0,
        IMM_J   = 3'd1,
        IMM_I   = 3'd2,
        IMM_B   = 3'd3,
        IMM_S   = 3'd4,
        IMM_CSR = 3'd5
    } imm_sel_e;

    // Replicate the instruction sign bit into the upper bits of a narrow immediate.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/immediate_extract.sv
// Combinational immediate extraction and sign extension for U/J/I/B/S formats.
// Select 5 decodes as CSR immediate only when IMMGEN_ZICSR_EN is defined.
module immediate_extract
    import imm_gen_pkg::*;
(
    input  logic [XLEN-1:0]  instruction_i,
    input  logic [SEL_W-1:0] select_i,
    output logic [XLEN-1:0]  immediate_o,
    output logic             illegal_o
);

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode_s;
    assign unused_opcode_s = ^instruction_i[6:0];

    // Decode select and assemble the selected immediate.
    always_comb begin
        immediate_o = {XLEN{1'b0}};
        illegal_o   = 1'b0;
        case (select_i)
            IMM_U: immediate_o = {instruction_i[31:12], 12'b0};
            IMM_J: immediate_o = {{(XLEN-20){instruction_i[31]}}, instruction_i[19:12],
                                  instruction_i[20], instruction_i[30:21], 1'b0};
            IMM_I: immediate_o = sext12(instruction_i[31:20]);
            IMM_B: immediate_o = {{(XLEN-12){instruction_i[31]}}, instruction_i[7],
                                  instruction_i[30:25], instruction_i[11:8], 1'b0};
            IMM_S: immediate_o = sext12({instruction_i[31:25], instruction_i[11:7]});
`ifdef IMMGEN_ZICSR_EN
            IMM_CSR: immediate_o = {27'b0, instruction_i[19:15]};
`endif
            default: begin
                immediate_o = {XLEN{1'b0}};
                illegal_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/immediate_generator.sv
// Registered RV32I immediate generator: extraction stage plus stallable output register.
// Optional CSR immediate on select 5 via IMMGEN_ZICSR_EN.
module immediate_generator
    import imm_gen_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [XLEN-1:0]  instruction,
    input  logic [SEL_W-1:0] immediateSelect,
    output logic [XLEN-1:0]  immediateOutput,
    output logic             illegalSelect
);

    logic [XLEN-1:0] imm_d;
    logic            illegal_d;
    logic [XLEN-1:0] imm_q;
    logic            illegal_q;

    immediate_extract u_extract (
        .instruction_i (instruction),
        .select_i      (immediateSelect),
        .immediate_o   (imm_d),
        .illegal_o     (illegal_d)
    );

    // Output pipeline register; reset wins over enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            imm_q     <= {XLEN{1'b0}};
            illegal_q <= 1'b0;
        end else if (enable) begin
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end else begin
            imm_q     <= imm_q;
            illegal_q <= illegal_q;
        end
    end

    assign immediateOutput = imm_q;
    assign illegalSelect   = illegal_q;

endmodule

// File: tb/tb_immediate_generator.sv
// Directed self-checking bench for immediate_generator (both IMMGEN_ZICSR_EN builds).
module tb_immediate_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] instruction;
    logic [2:0]  immediateSelect;
    logic [31:0] immediateOutput;
    logic        illegalSelect;

    int errors = 0;
    int checks = 0;

    immediate_generator dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .instruction     (instruction),
        .immediateSelect (immediateSelect),
        .immediateOutput (immediateOutput),
        .illegalSelect   (illegalSelect)
    );

    always #5 clock = ~clock;

    task automatic step(input logic rst, input logic en, input logic [2:0] sel, input logic [31:0] ins);
        @(negedge clock);
        reset = rst;
        enable = en;
        immediateSelect = sel;
        instruction = ins;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_state;
        step(1'b1, 1'b0, 3'd0, 32'h0000_0000);
        step(1'b1, 1'b0, 3'd0, 32'h0000_0000);
        checks++;
        if (immediateOutput !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", immediateOutput, 32'h0);
        end
        checks++;
        if (illegalSelect !== 1'b0) begin
            errors++;
            $display("FAIL reset_flag got=%b exp=0", illegalSelect);
        end
    endtask

    task automatic test_valid_formats;
        logic [2:0]  sel_v [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
        logic [31:0] ins_v [9] = '{32'h0000_00B7, 32'hFFFF_F0B7, 32'h0400_00EF,
                                   32'h0400_8103, 32'hFFF0_0093, 32'h0420_8063,
                                   32'h8000_0063, 32'h0420_8023, 32'hFE00_0FA3};
        logic [31:0] exp_v [9] = '{32'h0000_0000, 32'hFFFF_F000, 32'h0000_0040,
                                   32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0040,
                                   32'hFFFF_F000, 32'h0000_0040, 32'hFFFF_FFFF};
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b1, sel_v[k], ins_v[k]);
            checks++;
            if (immediateOutput !== exp_v[k]) begin
                errors++;
                $display("FAIL valid_%0d sel=%0d ins=%h got=%h exp=%h",
                         k, sel_v[k], ins_v[k], immediateOutput, exp_v[k]);
            end
            checks++;
            if (illegalSelect !== 1'b0) begin
                errors++;
                $display("FAIL valid_flag_%0d got=%b exp=0", k, illegalSelect);
            end
        end
    endtask

    task automatic test_reserved;
        logic exp_flag;
        for (int s = 5; s < 8; s++) begin
            // Preload a nonzero value so a stuck register is visible.
            step(1'b0, 1'b1, 3'd2, 32'hFFF0_0093);
            step(1'b0, 1'b1, 3'(s), 32'hFFFF_FFFF);
`ifdef IMMGEN_ZICSR_EN
            exp_flag = (s != 5);
`else
            exp_flag = 1'b1;
`endif
            if (exp_flag) begin
                checks++;
                if (immediateOutput !== 32'h0000_0000) begin
                    errors++;
                    $display("FAIL reserved_out sel=%0d got=%h exp=%h", s, immediateOutput, 32'h0);
                end
            end else begin
                checks++;
                if (immediateOutput !== 32'h0000_001F) begin
                    errors++;
                    $display("FAIL csr_ones_out got=%h exp=%h", immediateOutput, 32'h1F);
                end
            end
            checks++;
            if (illegalSelect !== exp_flag) begin
                errors++;
                $display("FAIL reserved_flag sel=%0d got=%b exp=%b", s, illegalSelect, exp_flag);
            end
        end
    endtask

    task automatic test_csr;
`ifdef IMMGEN_ZICSR_EN
        step(1'b0, 1'b1, 3'd5, 32'h000F_D073);
        checks++;
        if (immediateOutput !== 32'h0000_001F) begin
            errors++;
            $display("FAIL csr_out got=%h exp=%h", immediateOutput, 32'h1F);
        end
        checks++;
        if (illegalSelect !== 1'b0) begin
            errors++;
            $display("FAIL csr_flag got=%b exp=0", illegalSelect);
        end
`else
        step(1'b0, 1'b1, 3'd5, 32'h000F_D073);
        checks++;
        if (immediateOutput !== 32'h0000_0000 || illegalSelect !== 1'b1) begin
            errors++;
            $display("FAIL csr_disabled got=%h/%b exp=%h/1", immediateOutput, illegalSelect, 32'h0);
        end
`endif
    endtask

    task automatic test_stall;
        step(1'b0, 1'b1, 3'd2, 32'h0400_8103);
        checks++;
        if (immediateOutput !== 32'h0000_0040) begin
            errors++;
            $display("FAIL stall_load got=%h exp=%h", immediateOutput, 32'h40);
        end
        step(1'b0, 1'b0, 3'd2, 32'hFFF0_0093);
        step(1'b0, 1'b0, 3'd7, 32'hFFFF_FFFF);
        checks++;
        if (immediateOutput !== 32'h0000_0040 || illegalSelect !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got=%h/%b exp=%h/0", immediateOutput, illegalSelect, 32'h40);
        end
        step(1'b0, 1'b1, 3'd2, 32'hFFF0_0093);
        checks++;
        if (immediateOutput !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stall_resume got=%h exp=%h", immediateOutput, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_reset_midstream;
        step(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 3'd0, 32'hFFFF_F0B7);
        step(1'b1, 1'b0, 3'd0, 32'hFFFF_F0B7);
        checks++;
        if (immediateOutput !== 32'h0000_0000 || illegalSelect !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_enable got=%h/%b exp=%h/0", immediateOutput, illegalSelect, 32'h0);
        end
        step(1'b1, 1'b1, 3'd2, 32'hFFF0_0093);
        checks++;
        if (immediateOutput !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_priority got=%h exp=%h", immediateOutput, 32'h0);
        end
        step(1'b0, 1'b1, 3'd2, 32'hFFF0_0093);
        checks++;
        if (immediateOutput !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", immediateOutput, 32'hFFFFFFFF);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        instruction = 32'h0;
        immediateSelect = 3'd0;
        test_reset_state();
        test_valid_formats();
        test_reserved();
        test_csr();
        test_stall();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
